// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared states, default widths and tick derivation for tone_sequencer
package tone_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam int DEF_CLK_HZ    = 100_000_000;
   localparam int DEF_TICK_HZ   = 1000;
   localparam int DEF_DIV_W     = 20;
   localparam int DEF_DUR_W     = 16;
   localparam int DEF_GAP_TICKS = 10;

   function automatic int tick_cycles(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/tone_sequencer_tick_gen.sv
// rtl/tone_sequencer_tick_gen.sv - free-running duration time base, restartable
module tick_gen #(
   parameter int TICK_CYCLES = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int W = $clog2(TICK_CYCLES);
   localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || restart) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - one square-wave note per request, then a silent gap
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int CLK_HZ    = DEF_CLK_HZ,
   parameter int TICK_HZ   = DEF_TICK_HZ,
   parameter int DIV_W     = DEF_DIV_W,
   parameter int DUR_W     = DEF_DUR_W,
   parameter int GAP_TICKS = DEF_GAP_TICKS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [DIV_W-1:0] note_half_period,
   input  logic [DUR_W-1:0] note_duration,
   input  logic             stop,
   output logic             speaker,
   output logic             busy,
   output logic             done
);

   localparam int TICK_CYCLES = tick_cycles(CLK_HZ, TICK_HZ);
   // GAP_TICKS=0 never enters GAP, so the counter just needs a legal width.
   localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;

   state_t           state;
   logic [DIV_W-1:0] hp_q;
   logic [DIV_W-1:0] div_cnt;
   logic [DUR_W-1:0] dur_q;
   logic [DUR_W-1:0] dur_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             tick;
   logic             play_last;
   logic             restart;

   // Holding the time base at zero in IDLE aligns the first tick to the accept edge.
   assign play_last = (state == ST_PLAY) && tick && (dur_cnt == dur_q - DUR_W'(1));
   assign restart   = (state == ST_IDLE) || play_last;

   tick_gen #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         hp_q       <= '0;
         dur_q      <= '0;
         div_cnt    <= '0;
         dur_cnt    <= '0;
         gap_cnt    <= '0;
         speaker    <= 1'b0;
         done       <= 1'b0;
         note_ready <= 1'b1;
         busy       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (note_valid && !stop) begin
                  hp_q    <= note_half_period;
                  dur_q   <= note_duration;
                  div_cnt <= '0;
                  dur_cnt <= '0;
                  gap_cnt <= '0;
                  speaker <= 1'b0;
                  if (note_duration != '0) begin
                     state      <= ST_PLAY;
                     note_ready <= 1'b0;
                     busy       <= 1'b1;
                  end else if (GAP_TICKS > 0) begin
                     state      <= ST_GAP;
                     note_ready <= 1'b0;
                     busy       <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_PLAY: begin
               if (stop) begin
                  state      <= ST_IDLE;
                  note_ready <= 1'b1;
                  busy       <= 1'b0;
                  speaker    <= 1'b0;
                  done       <= 1'b1;
               end else begin
                  if (hp_q != '0) begin
                     if (div_cnt == hp_q - DIV_W'(1)) begin
                        div_cnt <= '0;
                        speaker <= ~speaker;
                     end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                     end
                  end
                  if (tick) begin
                     dur_cnt <= dur_cnt + DUR_W'(1);
                  end
                  // Last tick of the note overrides any toggle on the same edge.
                  if (play_last) begin
                     speaker <= 1'b0;
                     dur_cnt <= '0;
                     if (GAP_TICKS > 0) begin
                        state <= ST_GAP;
                     end else begin
                        state      <= ST_IDLE;
                        note_ready <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                     end
                  end
               end
            end
            ST_GAP: begin
               speaker <= 1'b0;
               if (stop || (tick && gap_cnt == GAP_LAST)) begin
                  state      <= ST_IDLE;
                  note_ready <= 1'b1;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  gap_cnt    <= '0;
               end else if (tick) begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               state      <= ST_IDLE;
               note_ready <= 1'b1;
               busy       <= 1'b0;
               speaker    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised successor to the fixed-divider speaker driver.
- Plays one square-wave note per request: programmable half-period, programmable duration in ticks, then a fixed silent gap.
- Sits between a note source (ROM player, keypad decoder) and the speaker pin.
- Provides a valid/ready request handshake, a stop control, and busy/done status.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 1000, duration time base in Hz. TICK_CYCLES = CLK_HZ/TICK_HZ; must be an integer ≥ 2.
- DIV_W, 20, width of the half-period field, in clk cycles.
- DUR_W, 16, width of the duration field, in ticks.
- GAP_TICKS, 10, silent ticks inserted after every note. 0 means no gap.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- rst_n, input, 1, synchronous active-low reset.
- note_valid, input, 1, request present.
- note_ready, output, 1, block can accept a request.
- note_half_period, input, DIV_W, clk cycles per speaker half-cycle. 0 means rest (silence).
- note_duration, input, DUR_W, note length in ticks.
- stop, input, 1, abort the current note or gap.
- speaker, output, 1, square-wave output.
- busy, output, 1, high in PLAY or GAP.
- done, output, 1, one-cycle pulse when a request completes or is aborted.

Behaviour:
- Reset (rst_n low at a clk edge) has priority over everything:
  - state=IDLE; all counters cleared.
  - speaker=0, busy=0, done=0, note_ready=1.
  - Reset mid-note drops the note with no done pulse.
- States: IDLE, PLAY, GAP. Encoding is defined in the package.
- note_ready = (state==IDLE). It is registered and equals the state, so it has no combinational path from inputs.
- Accept occurs when note_valid && note_ready at a clk edge:
  - Latch half-period and duration.
  - Clear the divider counter, tick counter and duration counter.
  - speaker=0; next state=PLAY.
- Zero-duration request: accepted, PLAY is skipped, goes to GAP (or to IDLE if GAP_TICKS=0).
  - done pulses at the same point a normal note would end.
- Tick generator: counts 0..TICK_CYCLES-1 and emits a one-cycle tick on the last count.
  - It is restarted on every accept and every PLAY→GAP transition, so PLAY lasts exactly duration×TICK_CYCLES cycles.
- PLAY, divider:
  - The divider counts 0..hp-1.
  - When the counter is at hp-1 it wraps to 0 and speaker toggles.
  - Resulting period is 2×hp cycles. hp=1 gives clk/2.
  - With hp=0 the divider stays at 0 and speaker stays 0.
- PLAY, exit:
  - On each tick the duration counter increments.
  - When it reaches the latched duration, speaker is forced to 0 on the same edge and the next state is GAP.
- GAP:
  - speaker=0.
  - Counts GAP_TICKS ticks, then goes to IDLE with done=1 for that single cycle.
  - If GAP_TICKS=0, PLAY goes directly to IDLE and done pulses on the exit edge.
- done timing: done is registered and high for exactly one cycle, coincident with the first IDLE cycle. A new request can be accepted that same cycle.
- stop (when not in reset) from PLAY or GAP:
  - Next state IDLE, speaker=0, done=1 for one cycle.
  - stop in IDLE is ignored. If stop and note_valid are both high in IDLE, stop wins and there is no accept.
- busy = state!=IDLE, registered.
- Inputs are ignored while busy; latched values do not change mid-note.
- Counters are sized so that they never overflow:
  - Divider: DIV_W bits.
  - Duration: DUR_W bits.
  - Tick: $clog2(TICK_CYCLES) bits.
  - Gap: $clog2(GAP_TICKS+1) bits.

Decomposition:
- Package tone_pkg contains:
  - The state enum (IDLE, PLAY, GAP).
  - The TICK_CYCLES derivation function.
  - Default widths.
- One sub-module, tick_gen: parameter TICK_CYCLES; ports clk, rst_n, restart, tick.
- Divider, duration/gap counting and FSM live in tone_sequencer.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (TICK_CYCLES=10), GAP_TICKS=2, DIV_W=8, DUR_W=8.
1. Reset: rst_n=0 for 3 cycles with note_valid=1 → speaker=0, busy=0, done=0, note_ready=1, no accept; first accept occurs on the first edge with rst_n=1.
2. hp=3, dur=4 → speaker toggles every 3 cycles (period 6); PLAY lasts 40 cycles; GAP lasts 20 cycles with speaker=0; done pulses once, 60 cycles after accept; note_ready returns to 1.
3. hp=0, dur=2 → speaker stays 0 for the whole 20-cycle PLAY and 20-cycle GAP; done pulses at cycle 40.
4. dur=0 → no toggles; GAP of 20 cycles; done pulses at cycle 20.
5. stop asserted at cycle 15 of a hp=2, dur=5 note → next cycle speaker=0, IDLE, done=1 for one cycle; a new note_valid in that done cycle is accepted.
6. note_valid held high with changing hp while busy → no second accept; waveform period stays at the latched hp; rst_n=0 mid-PLAY → IDLE next edge with no done pulse.
